// File: rtl/inst_queue.sv
// Show-ahead instruction FIFO between fetch and decode. The head entry is read
// combinationally from the storage arrays, and a mispredict clear empties the queue.
module inst_queue #(
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4,
  parameter int INST_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              IF_valid,
  input  logic [INST_W-1:0] IF_inst,
  input  logic [ADDR_W-1:0] IF_pc,
  output logic              IF_queue_is_full,
  input  logic              ID_enable,
  output logic              ID_queue_is_empty,
  output logic [INST_W-1:0] ID_inst,
  output logic [ADDR_W-1:0] ID_pc,
  input  logic              ROB_clear
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [INST_W-1:0] mem_inst [DEPTH];
  logic [ADDR_W-1:0] mem_pc   [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              push_ok, pop_ok;

  // Both flags depend only on the registered count, never on this cycle's requests.
  assign IF_queue_is_full  = (count_q == FULL_CNT);
  assign ID_queue_is_empty = (count_q == '0);

  assign push_ok = IF_valid  && !IF_queue_is_full;
  assign pop_ok  = ID_enable && !ID_queue_is_empty;

  assign ID_inst = ID_queue_is_empty ? '0 : mem_inst[head_q];
  assign ID_pc   = ID_queue_is_empty ? '0 : mem_pc[head_q];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy) begin
      if (ROB_clear) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (push_ok) tail_d = tail_q + PTR_W'(1);
        if (pop_ok)  head_d = head_q + PTR_W'(1);
        case ({push_ok, pop_ok})
          2'b10:   count_d = count_q + (PTR_W+1)'(1);
          2'b01:   count_d = count_q - (PTR_W+1)'(1);
          default: count_d = count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && !ROB_clear && push_ok) begin
      mem_inst[tail_q] <= IF_inst;
      mem_pc[tail_q]   <= IF_pc;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: directed steps plus a random phase, checked against a queue model.
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst, rdy, IF_valid, ID_enable, ROB_clear;
  logic [31:0] IF_inst, IF_pc;
  logic        IF_queue_is_full, ID_queue_is_empty;
  logic [31:0] ID_inst, ID_pc;

  int n_total = 0;
  int n_pass  = 0;

  logic [63:0] model_q [$];

  always #5 clk = ~clk;

  inst_queue dut (
    .clk               (clk),
    .rst               (rst),
    .rdy               (rdy),
    .IF_valid          (IF_valid),
    .IF_inst           (IF_inst),
    .IF_pc             (IF_pc),
    .IF_queue_is_full  (IF_queue_is_full),
    .ID_enable         (ID_enable),
    .ID_queue_is_empty (ID_queue_is_empty),
    .ID_inst           (ID_inst),
    .ID_pc             (ID_pc),
    .ROB_clear         (ROB_clear)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic check_outputs(input string phase);
    logic [31:0] e_inst, e_pc;
    logic        e_empty, e_full;
    e_empty = (model_q.size() == 0);
    e_full  = (model_q.size() == 16);
    e_inst  = e_empty ? 32'h0 : model_q[0][63:32];
    e_pc    = e_empty ? 32'h0 : model_q[0][31:0];
    chk({phase, " empty"}, {31'h0, ID_queue_is_empty}, {31'h0, e_empty});
    chk({phase, " full"},  {31'h0, IF_queue_is_full},  {31'h0, e_full});
    chk({phase, " inst"},  ID_inst, e_inst);
    chk({phase, " pc"},    ID_pc,   e_pc);
    $display("[%0t] %s: size=%0d empty=%b full=%b head_pc=%h", $time, phase,
             model_q.size(), ID_queue_is_empty, IF_queue_is_full, ID_pc);
  endtask

  // One clock cycle: drive inputs, check outputs are unaffected by this cycle's requests,
  // advance the reference queue at the edge, then check post-edge outputs.
  task automatic cycle(input string phase, input logic v, input logic [31:0] inst,
                       input logic [31:0] pc, input logic en, input logic clr,
                       input logic r, input logic rs);
    logic was_full, was_empty;
    IF_valid  = v;
    IF_inst   = inst;
    IF_pc     = pc;
    ID_enable = en;
    ROB_clear = clr;
    rdy       = r;
    rst       = rs;
    #2;
    if (!rs) check_outputs({phase, " pre"});
    @(posedge clk);
    was_full  = (model_q.size() == 16);
    was_empty = (model_q.size() == 0);
    if (rs) model_q.delete();
    else if (r) begin
      if (clr) model_q.delete();
      else begin
        if (en && !was_empty) void'(model_q.pop_front());
        if (v && !was_full)   model_q.push_back({inst, pc});
      end
    end
    #1;
    check_outputs(phase);
  endtask

  task automatic push(input string phase, input logic [31:0] pc);
    cycle(phase, 1'b1, 32'h13 + pc, pc, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic pop(input string phase);
    cycle(phase, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; IF_valid = 1'b0; ID_enable = 1'b0; ROB_clear = 1'b0;
    IF_inst = '0; IF_pc = '0;
    @(posedge clk); #1;

    // Reset
    cycle("reset", 1'b1, 32'h13, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle("idle", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Three pushes, then pops through empty and one extra pop
    for (int i = 0; i < 3; i++) push("t1 push", 32'(i * 4));
    for (int i = 0; i < 4; i++) pop("t2 pop");

    // Fill to full, overflow push dropped, drain across the wrap
    for (int i = 0; i < 16; i++) push("t3 fill", 32'(i * 4));
    push("t3 overflow", 32'h40);
    cycle("t3 full push+pop", 1'b1, 32'h53, 32'h40, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) pop("t3 drain");
    cycle("t3 empty push+pop", 1'b1, 32'h77, 32'h80, 1'b1, 1'b0, 1'b1, 1'b0);
    pop("t3 drain last");

    // Steady occupancy of 8 with simultaneous push and pop
    for (int i = 0; i < 8; i++) push("t4 fill", 32'h1000 + 32'(i * 4));
    for (int i = 0; i < 20; i++)
      cycle("t4 stream", 1'b1, $urandom, 32'h2000 + 32'(i * 4), 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) pop("t4 drain");

    // Flush discards the same-cycle push
    for (int i = 0; i < 5; i++) push("t5 fill", 32'h300 + 32'(i * 4));
    cycle("t5 clear", 1'b1, 32'h113, 32'h100, 1'b1, 1'b1, 1'b1, 1'b0);
    push("t5 after clear", 32'h200);
    pop("t5 drain");

    // rdy=0 freezes everything, then ordering resumes
    for (int i = 0; i < 3; i++) push("t6 fill", 32'h400 + 32'(i * 4));
    for (int i = 0; i < 4; i++)
      cycle("t6 frozen", $urandom_range(0, 1) == 1, $urandom, $urandom,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) pop("t6 resume");
    push("t6 pre-rst", 32'h500);
    push("t6 pre-rst", 32'h504);
    cycle("t6 rst", 1'b1, 32'h0, 32'h508, 1'b1, 1'b0, 1'b1, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cycle("rand", $urandom_range(0, 9) < 7, $urandom, $urandom,
            $urandom_range(0, 9) < 5, $urandom_range(0, 99) < 3,
            $urandom_range(0, 9) != 0, $urandom_range(0, 199) == 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
